seq_detect_ctrl: RTL

Run controller for a programmable serial pattern detector.
- Loads a PAT_W-bit pattern and run limits.
- Arms on start and pulls bits from a serial source over a valid/ready handshake.
- Counts matches, in overlapping or non-overlapping mode, and terminates on a match quota, a bit budget or abort.
- Sits between a serial bit source and a status/interrupt consumer.
- Generalises the fixed "1001" detector into a reusable, sequenced resource.

---
 rtl/seq_detect_ctrl_pkg.sv | 39 +++
 rtl/seq_detect_ctrl_matcher.sv | 84 ++++++++
 rtl/seq_detect_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl_pkg
//  Brief    : Shared types and constants for the serial pattern detector
//             run controller: FSM state encoding, match flag values and
//             the power-on pattern.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_detect_ctrl_pkg;

    // Run-controller states. The encoding is fixed so that software reading
    // a debug view of the state sees the same values across revisions.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Matcher result flag values.
    localparam logic c_found    = 1'b1;
    localparam logic c_notfound = 1'b0;

    // Power-on pattern; the low PAT_W bits are used, so a 4-bit detector
    // wakes up looking for "1001".
    localparam logic [7:0] c_default_pattern = 8'b0000_1001;

    // Saturating increment helper for the match and bit counters. Callers
    // pass the counter zero-extended to 32 bits together with its maximum
    // value; the result is returned at the same 32-bit width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        if (value >= max_value) begin
            return max_value;
        end
        return value + 32'd1;
    endfunction

endpackage : seq_detect_ctrl_pkg
`default_nettype wire

// File: rtl/seq_detect_ctrl_matcher.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_matcher
//  Brief    : History shift register, fill counter and pattern compare for
//             the serial detector. hit_o is combinational and only valid on
//             a cycle where shift_en_i is high.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_matcher
    import seq_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             clr_i,        // wipe history and fill
    input  logic             shift_en_i,   // a bit is accepted this cycle
    input  logic             bit_i,
    input  logic             overlap_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             hit_o
);

    // Fill counts how many fresh bits are in the history, up to PAT_W.
    localparam int               FILL_W      = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    logic [PAT_W-1:0]  w_hist_shift;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_hit;

    // Post-shift history/fill and the match decision for the incoming bit.
    always_comb begin
        w_hist_shift = {hist_q[PAT_W-2:0], bit_i};
        if (fill_q == c_fill_full) begin
            w_fill_inc = c_fill_full;
        end else begin
            w_fill_inc = fill_q + FILL_W'(1);
        end
        if (shift_en_i && (w_fill_inc == c_fill_full) && (w_hist_shift == pattern_i)) begin
            w_hit = c_found;
        end else begin
            w_hit = c_notfound;
        end
    end

    assign hit_o = w_hit;

    // Next history/fill: clear wins; a non-overlapping match restarts the
    // fill so the following match needs PAT_W fresh bits.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en_i) begin
            hist_d = w_hist_shift;
            if (w_hit && !overlap_i) begin
                fill_d = '0;
            end else begin
                fill_d = w_fill_inc;
            end
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule : seq_pattern_matcher
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl
//  Brief    : Run controller for a programmable serial pattern detector.
//             Holds the configuration, sequences IDLE/RUN/DONE, pulls bits
//             over a valid/ready handshake, counts matches and ends the run
//             on a match quota, a bit budget or an abort.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,            // asynchronous, active-low
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_max_matches,
    input  logic [LEN_W-1:0] cfg_max_bits,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [PAT_W-1:0] c_pattern_rst = c_default_pattern[PAT_W-1:0];
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;
    localparam logic [LEN_W-1:0] c_len_max     = '1;

    // Configuration registers.
    logic [PAT_W-1:0] pattern_q,     pattern_d;
    logic             overlap_q,     overlap_d;
    logic [CNT_W-1:0] max_matches_q, max_matches_d;
    logic [LEN_W-1:0] max_bits_q,    max_bits_d;

    // Run state.
    state_e           state_q,       state_d;
    logic [LEN_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic [CNT_W-1:0] match_cnt_q,   match_cnt_d;
    logic             match_q,       match_d;
    logic             done_q,        done_d;
    logic             timeout_q,     timeout_d;

    logic             w_running;
    logic             w_ready;
    logic             w_accept;
    logic             w_start_go;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_new;
    logic [LEN_W-1:0] w_bits_new;
    logic             w_quota;
    logic             w_budget;

    // Handshake and start qualification; abort blocks acceptance in the
    // same cycle it is asserted.
    always_comb begin
        w_running  = (state_q == RUN);
        w_ready    = w_running && !abort;
        w_accept   = w_ready && in_valid;
        w_start_go = start && !w_running;
    end

    seq_pattern_matcher #(
        .PAT_W      (PAT_W)
    ) u_matcher (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (w_start_go),
        .shift_en_i (w_accept),
        .bit_i      (in_bit),
        .overlap_i  (overlap_q),
        .pattern_i  (pattern_q),
        .hit_o      (w_hit)
    );

    // Post-bit counter values and the two termination conditions; the
    // quota check is evaluated first so it wins on a shared final bit.
    always_comb begin
        w_bits_new = LEN_W'(sat_inc(32'(bit_cnt_q), 32'(c_len_max)));
        if (w_hit) begin
            w_cnt_new = CNT_W'(sat_inc(32'(match_cnt_q), 32'(c_cnt_max)));
        end else begin
            w_cnt_new = match_cnt_q;
        end
        w_quota  = w_accept && (max_matches_q != '0) && (w_cnt_new == max_matches_q);
        w_budget = w_accept && !w_quota && (max_bits_q != '0) && (w_bits_new == max_bits_q);
    end

    // Configuration writes are only taken while no run is in progress.
    always_comb begin
        pattern_d     = pattern_q;
        overlap_d     = overlap_q;
        max_matches_d = max_matches_q;
        max_bits_d    = max_bits_q;
        if (cfg_we && !w_running) begin
            pattern_d     = cfg_pattern;
            overlap_d     = cfg_overlap;
            max_matches_d = cfg_max_matches;
            max_bits_d    = cfg_max_bits;
        end
    end

    // FSM next state plus counter and status-flag updates.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        match_d     = c_notfound;
        done_d      = done_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE, DONE: begin
                if (w_start_go) begin
                    state_d     = RUN;
                    bit_cnt_d   = '0;
                    match_cnt_d = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (w_accept) begin
                    bit_cnt_d   = w_bits_new;
                    match_cnt_d = w_cnt_new;
                    match_d     = w_hit;
                    if (w_quota) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b0;
                    end else if (w_budget) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration registers, reset to the power-on pattern and no limits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q     <= c_pattern_rst;
            overlap_q     <= 1'b0;
            max_matches_q <= '0;
            max_bits_q    <= '0;
        end else begin
            pattern_q     <= pattern_d;
            overlap_q     <= overlap_d;
            max_matches_q <= max_matches_d;
            max_bits_q    <= max_bits_d;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            match_q     <= match_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign in_ready    = w_ready;
    assign busy        = w_running;
    assign match       = match_q;
    assign match_count = match_cnt_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule : seq_detect_ctrl
`default_nettype wire
